// File: rtl/radix2_quo_denorm_if.sv
// Handshake and data bundle between the SRT divider, the quotient
// de-normaliser and the downstream result consumer.
interface radix2_quo_denorm_if #(
  parameter int PSIZE = 8,
  parameter int OSIZE = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PSIZE-1:0] quotient;
  logic [3:0]       quoexp;
  logic             out_valid;
  logic             out_ready;
  logic [OSIZE-1:0] result;
  logic             dz;
  logic             ovf;

  // master side feeds quotients and consumes results
  modport master (
    output in_valid, quotient, quoexp, out_ready,
    input  in_ready, out_valid, result, dz, ovf
  );

  modport slave (
    input  in_valid, quotient, quoexp, out_ready,
    output in_ready, out_valid, result, dz, ovf
  );
endinterface

// File: rtl/radix2_quo_denorm.sv
// De-normalises the SRT divider quotient into an OSIZE-bit fixed-point result
// using a one-bit-per-cycle shifter, flagging divide-by-zero and saturation.
module radix2_quo_denorm #(
  parameter  int PSIZE = 8,
  parameter  int DSIZE = 8,
  parameter  int FBITS = 0,
  localparam int OSIZE = DSIZE + FBITS
) (
  input logic                 clock,
  input logic                 rst,
  radix2_quo_denorm_if.slave  bus
);
  localparam int W = PSIZE + OSIZE;
  localparam logic signed [6:0] NET_OFFS = 7'(FBITS - (PSIZE - 1));

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     acc, acc_nxt, acc_load, acc_shift;
  logic [4:0]       cnt, cnt_nxt, cnt_load;
  logic             left, left_nxt;
  logic             ovf, ovf_nxt, ovf_load, ovf_shift;
  logic             dz, dz_nxt;
  logic [OSIZE-1:0] result, result_nxt;
  logic signed [6:0] net;
  logic [6:0]       net_mag;

  assign net      = $signed({3'b000, bus.quoexp}) + NET_OFFS;
  assign net_mag  = net[6] ? 7'(-net) : 7'(net);
  assign cnt_load = net_mag[4:0];
  assign acc_load = {{OSIZE{1'b0}}, bus.quotient};
  assign ovf_load = |acc_load[W-1:OSIZE];

  // Overflow is sticky: once a one has crossed into the upper bits it stays flagged
  assign acc_shift = left ? (acc << 1) : (acc >> 1);
  assign ovf_shift = ovf | (left & (|acc_shift[W-1:OSIZE]));

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    left_nxt   = left;
    ovf_nxt    = ovf;
    dz_nxt     = dz;
    result_nxt = result;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          acc_nxt  = acc_load;
          cnt_nxt  = cnt_load;
          left_nxt = !net[6];
          dz_nxt   = 1'b0;
          ovf_nxt  = ovf_load;
          if (bus.quoexp == 4'hF) begin
            state_nxt  = HOLD;
            result_nxt = '1;
            dz_nxt     = 1'b1;
            ovf_nxt    = 1'b0;
          end else if (cnt_load == 5'd0) begin
            state_nxt  = HOLD;
            result_nxt = ovf_load ? '1 : acc_load[OSIZE-1:0];
          end else begin
            state_nxt  = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_nxt = acc_shift;
        cnt_nxt = cnt - 5'd1;
        ovf_nxt = ovf_shift;
        if (cnt == 5'd1) begin
          state_nxt  = HOLD;
          result_nxt = ovf_shift ? '1 : acc_shift[OSIZE-1:0];
        end
      end
      HOLD: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      left   <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      left   <= left_nxt;
      ovf    <= ovf_nxt;
      dz     <= dz_nxt;
      result <= result_nxt;
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.result    = result;
  assign bus.dz        = dz;
  assign bus.ovf       = ovf;
endmodule

// File: tb/tb_radix2_quo_denorm.sv
// Directed-vector bench for radix2_quo_denorm: default build plus an FBITS=4 build.
module tb_radix2_quo_denorm;
  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  radix2_quo_denorm_if #(.PSIZE(8), .OSIZE(8))  bus_a ();
  radix2_quo_denorm_if #(.PSIZE(8), .OSIZE(12)) bus_b ();

  radix2_quo_denorm #(.PSIZE(8), .DSIZE(8), .FBITS(0)) dut_a (
    .clock(clock), .rst(rst), .bus(bus_a.slave)
  );
  radix2_quo_denorm #(.PSIZE(8), .DSIZE(8), .FBITS(4)) dut_b (
    .clock(clock), .rst(rst), .bus(bus_b.slave)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] get_result(input bit sel);
    return sel ? 32'(bus_b.result) : 32'(bus_a.result);
  endfunction
  function automatic logic get_ov(input bit sel);
    return sel ? bus_b.out_valid : bus_a.out_valid;
  endfunction
  function automatic logic get_ir(input bit sel);
    return sel ? bus_b.in_ready : bus_a.in_ready;
  endfunction
  function automatic logic get_dz(input bit sel);
    return sel ? bus_b.dz : bus_a.dz;
  endfunction
  function automatic logic get_ovf(input bit sel);
    return sel ? bus_b.ovf : bus_a.ovf;
  endfunction

  task automatic apply_stimulus(input bit sel, input logic v, input logic [7:0] q,
                                input logic [3:0] e);
    if (sel) begin
      bus_b.in_valid = v; bus_b.quotient = q; bus_b.quoexp = e;
    end else begin
      bus_a.in_valid = v; bus_a.quotient = q; bus_a.quoexp = e;
    end
  endtask

  task automatic set_ready(input bit sel, input logic r);
    if (sel) bus_b.out_ready = r;
    else     bus_a.out_ready = r;
  endtask

  // One transaction: issue, measure latency, optionally stall, then release
  task automatic run_txn(input string tag, input bit sel, input logic [7:0] q,
                         input logic [3:0] e, input logic [31:0] exp_res,
                         input logic exp_dz, input logic exp_ovf,
                         input int exp_lat, input int hold);
    int lat;
    @(posedge clock); #1;
    check_output({tag, "/in_ready"}, 32'(get_ir(sel)), 32'd1);
    apply_stimulus(sel, 1'b1, q, e);
    @(posedge clock); #1;
    apply_stimulus(sel, 1'b0, 8'h00, 4'h0);
    lat = 1;
    while (!get_ov(sel) && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check_output({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, "/result"}, get_result(sel), exp_res);
    check_output({tag, "/dz"}, 32'(get_dz(sel)), 32'(exp_dz));
    check_output({tag, "/ovf"}, 32'(get_ovf(sel)), 32'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      apply_stimulus(sel, 1'b1, 8'h01, 4'hF);
      @(posedge clock); #1;
      check_output({tag, "/hold_result"}, get_result(sel), exp_res);
      check_output({tag, "/hold_dz"}, 32'(get_dz(sel)), 32'(exp_dz));
      check_output({tag, "/hold_ovf"}, 32'(get_ovf(sel)), 32'(exp_ovf));
      check_output({tag, "/hold_valid"}, 32'(get_ov(sel)), 32'd1);
      check_output({tag, "/hold_in_ready"}, 32'(get_ir(sel)), 32'd0);
    end
    apply_stimulus(sel, 1'b0, 8'h00, 4'h0);
    set_ready(sel, 1'b1);
    @(posedge clock); #1;
    set_ready(sel, 1'b0);
    check_output({tag, "/released_valid"}, 32'(get_ov(sel)), 32'd0);
    check_output({tag, "/released_in_ready"}, 32'(get_ir(sel)), 32'd1);
  endtask

  initial begin
    logic seen;
    apply_stimulus(1'b0, 1'b0, 8'h00, 4'h0);
    apply_stimulus(1'b1, 1'b0, 8'h00, 4'h0);
    set_ready(1'b0, 1'b0);
    set_ready(1'b1, 1'b0);

    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst/out_valid", 32'(bus_a.out_valid), 32'd0);
    check_output("rst/result", 32'(bus_a.result), 32'd0);
    check_output("rst/dz", 32'(bus_a.dz), 32'd0);
    check_output("rst/ovf", 32'(bus_a.ovf), 32'd0);
    check_output("rst/in_ready", 32'(bus_a.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("rst/in_ready_after", 32'(bus_a.in_ready), 32'd1);

    run_txn("div3",   1'b0, 8'h42, 4'd6,  32'd33,    1'b0, 1'b0, 2, 0);
    run_txn("div1",   1'b0, 8'd200, 4'd7, 32'd200,   1'b0, 1'b0, 1, 0);
    run_txn("rshift7",1'b0, 8'hFF, 4'd0,  32'd1,     1'b0, 1'b0, 8, 0);
    run_txn("fbits4", 1'b1, 8'd200, 4'd7, 32'hC80,   1'b0, 1'b0, 5, 0);
    run_txn("ovf",    1'b0, 8'hFF, 4'd14, 32'hFF,    1'b0, 1'b1, 8, 0);
    run_txn("dz",     1'b0, 8'h55, 4'hF,  32'hFF,    1'b1, 1'b0, 1, 5);
    run_txn("after",  1'b0, 8'h42, 4'd6,  32'd33,    1'b0, 1'b0, 2, 0);

    // Reset lands mid-shift; the pending result must be dropped
    @(posedge clock); #1;
    check_output("midrst/in_ready", 32'(bus_a.in_ready), 32'd1);
    apply_stimulus(1'b0, 1'b1, 8'hFF, 4'd0);
    @(posedge clock); #1;
    apply_stimulus(1'b0, 1'b0, 8'h00, 4'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst = 1'b1;
    #1;
    check_output("midrst/in_ready_rst", 32'(bus_a.in_ready), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    #1;
    check_output("midrst/out_valid", 32'(bus_a.out_valid), 32'd0);
    check_output("midrst/result", 32'(bus_a.result), 32'd0);
    check_output("midrst/dz", 32'(bus_a.dz), 32'd0);
    check_output("midrst/ovf", 32'(bus_a.ovf), 32'd0);
    check_output("midrst/in_ready_after", 32'(bus_a.in_ready), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      seen = seen | bus_a.out_valid;
    end
    check_output("midrst/never_valid", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
